multiport_ram_wr_queue: RTL and testbench

- Write-side staging buffer placed directly upstream of the 2R/2W multiport RAM.
- Accepts up to two write requests per cycle from producers (e.g. writeback/commit) through valid/ready handshakes and holds them in an in-order circular queue.
- Drains up to two entries per cycle onto the RAM's wra/wrb write ports.
- Reports whether either RAM read address has a write still queued, so the consumer can stall instead of reading stale data.

---
 rtl/multiport_ram_wr_queue_pkg.sv | 27 ++
 rtl/multiport_ram_wr_queue_if.sv | 57 +++++
 rtl/multiport_ram_wr_queue.sv | 113 +++++++++++
 tb/tb_multiport_ram_wr_queue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multiport_ram_wr_queue_pkg.sv
//==============================================================================
// Module : multiport_ram_pkg
// Brief  : Shared types and pointer helper for the multiport RAM write queue.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package multiport_ram_pkg;

    localparam int C_DEF_MEM_DEPTH   = 2048;
    localparam int C_DEF_MEM_WIDTH   = 32;
    localparam int C_DEF_INDEX_WIDTH = $clog2(C_DEF_MEM_DEPTH);

    typedef struct packed {
        logic [C_DEF_INDEX_WIDTH-1:0] addr;
        logic [C_DEF_MEM_WIDTH-1:0]   data;
    } wr_req_t;

    function automatic int unsigned q_ptr_inc(input int unsigned ptr,
                                              input int unsigned step,
                                              input int unsigned depth);
        return (ptr + step) % depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multiport_ram_wr_queue_if.sv
//==============================================================================
// Module : multiport_ram_wr_queue_if
// Brief  : Producer, RAM write-port and read-snoop bundle for the write queue.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface multiport_ram_wr_queue_if #(
    parameter int P_INDEX_WIDTH = 11,
    parameter int P_MEM_WIDTH   = 32,
    parameter int P_CNT_WIDTH   = 4
);
    logic [P_INDEX_WIDTH-1:0] in0_addr_i;
    logic [P_MEM_WIDTH-1:0]   in0_data_i;
    logic                     in0_valid_i;
    logic                     in0_ready_o;
    logic [P_INDEX_WIDTH-1:0] in1_addr_i;
    logic [P_MEM_WIDTH-1:0]   in1_data_i;
    logic                     in1_valid_i;
    logic                     in1_ready_o;
    logic                     drain_en_i;
    logic [P_INDEX_WIDTH-1:0] wra_addr_o;
    logic [P_MEM_WIDTH-1:0]   wra_data_o;
    logic                     wra_valid_o;
    logic [P_INDEX_WIDTH-1:0] wrb_addr_o;
    logic [P_MEM_WIDTH-1:0]   wrb_data_o;
    logic                     wrb_valid_o;
    logic [P_INDEX_WIDTH-1:0] rda_addr_i;
    logic [P_INDEX_WIDTH-1:0] rdb_addr_i;
    logic                     rda_pending_o;
    logic                     rdb_pending_o;
    logic [P_CNT_WIDTH-1:0]   count_o;
    logic                     empty_o;
    logic                     full_o;

    modport master (
        output in0_addr_i, in0_data_i, in0_valid_i,
        output in1_addr_i, in1_data_i, in1_valid_i,
        output drain_en_i, rda_addr_i, rdb_addr_i,
        input  in0_ready_o, in1_ready_o,
        input  wra_addr_o, wra_data_o, wra_valid_o,
        input  wrb_addr_o, wrb_data_o, wrb_valid_o,
        input  rda_pending_o, rdb_pending_o, count_o, empty_o, full_o
    );

    modport slave (
        input  in0_addr_i, in0_data_i, in0_valid_i,
        input  in1_addr_i, in1_data_i, in1_valid_i,
        input  drain_en_i, rda_addr_i, rdb_addr_i,
        output in0_ready_o, in1_ready_o,
        output wra_addr_o, wra_data_o, wra_valid_o,
        output wrb_addr_o, wrb_data_o, wrb_valid_o,
        output rda_pending_o, rdb_pending_o, count_o, empty_o, full_o
    );
endinterface

`default_nettype wire

// File: rtl/multiport_ram_wr_queue.sv
//==============================================================================
// Module : multiport_ram_wr_queue
// Brief  : Dual-enqueue / dual-drain in-order write staging queue with
//          same-address coalescing and read-address pending snoop.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module multiport_ram_wr_queue
    import multiport_ram_pkg::*;
#(
    parameter int P_MEM_DEPTH = 2048,
    parameter int P_MEM_WIDTH = 32,
    parameter int P_Q_DEPTH   = 8
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_n_i,
    multiport_ram_wr_queue_if.slave     bus
);

    localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH);
    localparam int LP_CNT_WIDTH   = $clog2(P_Q_DEPTH) + 1;
    localparam int LP_PTR_WIDTH   = $clog2(P_Q_DEPTH);

    localparam logic [LP_CNT_WIDTH-1:0] C_DEPTH    = LP_CNT_WIDTH'(P_Q_DEPTH);
    localparam logic [LP_CNT_WIDTH-1:0] C_RDY0_MAX = LP_CNT_WIDTH'(P_Q_DEPTH - 1);
    localparam logic [LP_CNT_WIDTH-1:0] C_RDY1_MAX = LP_CNT_WIDTH'(P_Q_DEPTH - 2);
    localparam logic [LP_CNT_WIDTH-1:0] C_ZERO     = '0;
    localparam logic [LP_CNT_WIDTH-1:0] C_ONE      = LP_CNT_WIDTH'(1);
    localparam logic [LP_CNT_WIDTH-1:0] C_TWO      = LP_CNT_WIDTH'(2);

    logic [LP_INDEX_WIDTH-1:0] r_addr [P_Q_DEPTH];
    logic [P_MEM_WIDTH-1:0]    r_data [P_Q_DEPTH];
    logic [LP_PTR_WIDTH-1:0]   r_head;
    logic [LP_PTR_WIDTH-1:0]   r_tail;
    logic [LP_CNT_WIDTH-1:0]   r_count;

    logic                      w_rdy0, w_rdy1, w_acc0, w_acc1;
    logic                      w_pop_a, w_pop_b, w_coalesce;
    logic [LP_PTR_WIDTH-1:0]   w_head1, w_tail1, w_wr1_idx;
    logic [LP_CNT_WIDTH-1:0]   w_n_acc, w_n_pop;
    logic [P_Q_DEPTH-1:0]      w_hit_a, w_hit_b;

    // Ready looks only at the registered count; drains grant no same-cycle credit.
    assign w_rdy0 = rst_n_i && (r_count <= C_RDY0_MAX);
    assign w_rdy1 = rst_n_i && (r_count <= C_RDY1_MAX);
    assign w_acc0 = bus.in0_valid_i && w_rdy0;
    assign w_acc1 = bus.in1_valid_i && w_rdy1;

    assign w_pop_a = rst_n_i && bus.drain_en_i && (r_count >= C_ONE);
    assign w_pop_b = rst_n_i && bus.drain_en_i && (r_count >= C_TWO);

    assign w_head1   = LP_PTR_WIDTH'(q_ptr_inc(32'(r_head), 32'd1, P_Q_DEPTH));
    assign w_tail1   = LP_PTR_WIDTH'(q_ptr_inc(32'(r_tail), 32'd1, P_Q_DEPTH));
    assign w_wr1_idx = w_acc0 ? w_tail1 : r_tail;

    assign w_n_acc = LP_CNT_WIDTH'(w_acc0) + LP_CNT_WIDTH'(w_acc1);
    assign w_n_pop = LP_CNT_WIDTH'(w_pop_a) + LP_CNT_WIDTH'(w_pop_b);

    // Same-address pair: drop the older write, both entries still retire.
    assign w_coalesce = w_pop_b && (r_addr[r_head] == r_addr[w_head1]);

    assign bus.in0_ready_o = w_rdy0;
    assign bus.in1_ready_o = w_rdy1;
    assign bus.wra_addr_o  = r_addr[r_head];
    assign bus.wra_data_o  = r_data[r_head];
    assign bus.wra_valid_o = w_pop_a && !w_coalesce;
    assign bus.wrb_addr_o  = r_addr[w_head1];
    assign bus.wrb_data_o  = r_data[w_head1];
    assign bus.wrb_valid_o = w_pop_b;
    assign bus.count_o     = r_count;
    assign bus.empty_o     = !rst_n_i || (r_count == C_ZERO);
    assign bus.full_o      = rst_n_i && (r_count == C_DEPTH);

    // Slot i is occupied when its distance from head is below the count.
    for (genvar gi = 0; gi < P_Q_DEPTH; gi++) begin : g_snoop
        logic [LP_PTR_WIDTH-1:0] w_off;
        logic                    w_occ;
        assign w_off       = LP_PTR_WIDTH'(gi) - r_head;
        assign w_occ       = ({1'b0, w_off} < r_count);
        assign w_hit_a[gi] = w_occ && (r_addr[gi] == bus.rda_addr_i);
        assign w_hit_b[gi] = w_occ && (r_addr[gi] == bus.rdb_addr_i);
    end

    assign bus.rda_pending_o = rst_n_i && (|w_hit_a);
    assign bus.rdb_pending_o = rst_n_i && (|w_hit_b);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= LP_PTR_WIDTH'(q_ptr_inc(32'(r_head), 32'(w_n_pop), P_Q_DEPTH));
            r_tail  <= LP_PTR_WIDTH'(q_ptr_inc(32'(r_tail), 32'(w_n_acc), P_Q_DEPTH));
            r_count <= r_count + w_n_acc - w_n_pop;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_acc0) begin
            r_addr[r_tail] <= bus.in0_addr_i;
            r_data[r_tail] <= bus.in0_data_i;
        end
        if (w_acc1) begin
            r_addr[w_wr1_idx] <= bus.in1_addr_i;
            r_data[w_wr1_idx] <= bus.in1_data_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiport_ram_wr_queue.sv
//==============================================================================
// Module : tb_multiport_ram_wr_queue
// Brief  : Directed plus random checks of the write queue against a queue model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_multiport_ram_wr_queue;

    localparam int D  = 8;
    localparam int IW = 11;
    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct {
        logic [IW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    multiport_ram_wr_queue_if #(.P_INDEX_WIDTH(IW), .P_MEM_WIDTH(DW), .P_CNT_WIDTH(CW)) bus();

    multiport_ram_wr_queue #(.P_MEM_DEPTH(2048), .P_MEM_WIDTH(DW), .P_Q_DEPTH(D)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit v0, input logic [IW-1:0] a0, input logic [DW-1:0] d0,
                          input bit v1, input logic [IW-1:0] a1, input logic [DW-1:0] d1,
                          input bit dr);
        bus.in0_valid_i = v0; bus.in0_addr_i = a0; bus.in0_data_i = d0;
        bus.in1_valid_i = v1; bus.in1_addr_i = a1; bus.in1_data_i = d1;
        bus.drain_en_i  = dr;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic step();
        int n;
        bit r0, r1, ea, eb, coal, pa, pb;
        @(negedge clk);
        n    = q.size();
        r0   = (n <= D - 1);
        r1   = (n <= D - 2);
        ea   = bus.drain_en_i && (n >= 1);
        eb   = bus.drain_en_i && (n >= 2);
        coal = 1'b0;
        if (eb) coal = (q[0].addr == q[1].addr);
        pa = 1'b0; pb = 1'b0;
        foreach (q[i]) begin
            if (q[i].addr == bus.rda_addr_i) pa = 1'b1;
            if (q[i].addr == bus.rdb_addr_i) pb = 1'b1;
        end
        chk("in0_ready", 64'(bus.in0_ready_o), 64'(r0));
        chk("in1_ready", 64'(bus.in1_ready_o), 64'(r1));
        chk("count", 64'(bus.count_o), 64'(n));
        chk("empty", 64'(bus.empty_o), 64'(n == 0));
        chk("full", 64'(bus.full_o), 64'(n == D));
        chk("rda_pending", 64'(bus.rda_pending_o), 64'(pa));
        chk("rdb_pending", 64'(bus.rdb_pending_o), 64'(pb));
        chk("wra_valid", 64'(bus.wra_valid_o), 64'(ea && !coal));
        chk("wrb_valid", 64'(bus.wrb_valid_o), 64'(eb));
        if (ea && !coal) begin
            chk("wra_addr", 64'(bus.wra_addr_o), 64'(q[0].addr));
            chk("wra_data", 64'(bus.wra_data_o), 64'(q[0].data));
        end
        if (eb) begin
            chk("wrb_addr", 64'(bus.wrb_addr_o), 64'(q[1].addr));
            chk("wrb_data", 64'(bus.wrb_data_o), 64'(q[1].data));
        end
        @(posedge clk);
        if (ea) void'(q.pop_front());
        if (eb) void'(q.pop_front());
        if (bus.in0_valid_i && r0) q.push_back('{bus.in0_addr_i, bus.in0_data_i});
        if (bus.in1_valid_i && r1) q.push_back('{bus.in1_addr_i, bus.in1_data_i});
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk("rst_in0_ready", 64'(bus.in0_ready_o), 64'd0);
            chk("rst_in1_ready", 64'(bus.in1_ready_o), 64'd0);
            chk("rst_wra_valid", 64'(bus.wra_valid_o), 64'd0);
            chk("rst_wrb_valid", 64'(bus.wrb_valid_o), 64'd0);
            chk("rst_rda_pending", 64'(bus.rda_pending_o), 64'd0);
            chk("rst_rdb_pending", 64'(bus.rdb_pending_o), 64'd0);
            chk("rst_empty", 64'(bus.empty_o), 64'd1);
            if (k > 0) chk("rst_count", 64'(bus.count_o), 64'd0);
            @(posedge clk);
            #1;
        end
        q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        set_in(0, '0, '0, 0, '0, '0, 0);
        bus.rda_addr_i = '0;
        bus.rdb_addr_i = '0;

        // Reset then idle
        do_reset(2);
        step();
        chk("idle_count", 64'(bus.count_o), 64'd0);

        // Dual enqueue with drain blocked, then drain both
        set_in(1, 11'h010, 32'hAAAA0001, 1, 11'h011, 32'hBBBB0002, 0);
        step();
        chk("dual_count", 64'(bus.count_o), 64'd2);
        set_in(0, '0, '0, 0, '0, '0, 1);
        #3;
        chk("dual_wra_addr", 64'(bus.wra_addr_o), 64'h010);
        chk("dual_wrb_data", 64'(bus.wrb_data_o), 64'hBBBB0002);
        step();
        chk("dual_drained", 64'(bus.count_o), 64'd0);

        // Coalescing pair
        set_in(1, 11'h020, 32'h1, 1, 11'h020, 32'h2, 0);
        step();
        set_in(0, '0, '0, 0, '0, '0, 1);
        #3;
        chk("coal_wra_valid", 64'(bus.wra_valid_o), 64'd0);
        chk("coal_wrb_data", 64'(bus.wrb_data_o), 64'h2);
        step();
        chk("coal_popped", 64'(bus.count_o), 64'd0);

        // Full boundary
        for (int i = 0; i < 3; i++) begin
            set_in(1, IW'(11'h030 + 2 * i), DW'(100 + i), 1, IW'(11'h031 + 2 * i), DW'(200 + i), 0);
            step();
        end
        set_in(1, 11'h040, 32'h77, 0, '0, '0, 0);
        step();
        chk("fill7_in1_ready", 64'(bus.in1_ready_o), 64'd0);
        chk("fill7_in0_ready", 64'(bus.in0_ready_o), 64'd1);
        set_in(1, 11'h041, 32'h88, 0, '0, '0, 0);
        step();
        chk("full_flag", 64'(bus.full_o), 64'd1);
        chk("full_in0_ready", 64'(bus.in0_ready_o), 64'd0);
        set_in(1, 11'h050, 32'h99, 1, 11'h051, 32'h9A, 1);
        step();
        chk("full_drain_count", 64'(bus.count_o), 64'd6);
        set_in(0, '0, '0, 0, '0, '0, 1);
        repeat (3) step();

        // Pending snoop
        set_in(1, 11'h155, 32'h5555, 0, '0, '0, 0);
        bus.rda_addr_i = 11'h155;
        bus.rdb_addr_i = 11'h156;
        step();
        chk("pend_a_hit", 64'(bus.rda_pending_o), 64'd1);
        chk("pend_b_miss", 64'(bus.rdb_pending_o), 64'd0);
        set_in(0, '0, '0, 0, '0, '0, 1);
        step();
        chk("pend_a_cleared", 64'(bus.rda_pending_o), 64'd0);

        // Reset mid-operation
        set_in(1, 11'h060, 32'h60, 1, 11'h061, 32'h61, 0);
        repeat (2) step();
        set_in(1, 11'h062, 32'h62, 0, '0, '0, 0);
        step();
        chk("mid_count5", 64'(bus.count_o), 64'd5);
        set_in(0, '0, '0, 0, '0, '0, 1);
        do_reset(1);
        chk("mid_rst_count", 64'(bus.count_o), 64'd0);
        repeat (3) step();

        // Random mixed traffic with pointer wrap
        for (int i = 0; i < 60; i++) begin
            set_in(1'($urandom_range(0, 1)), IW'(11'h100 + $urandom_range(0, 3)), DW'($urandom),
                   1'($urandom_range(0, 1)), IW'(11'h100 + $urandom_range(0, 3)), DW'($urandom),
                   1'($urandom_range(0, 2) != 0));
            bus.rda_addr_i = IW'(11'h100 + $urandom_range(0, 4));
            bus.rdb_addr_i = IW'(11'h100 + $urandom_range(0, 4));
            step();
        end
        set_in(0, '0, '0, 0, '0, '0, 1);
        repeat (5) step();
        chk("final_empty", 64'(bus.empty_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
